muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit for the MIPS execute stage, directly upstream of the HI/LO register file. Accepts MULT/MULTU/DIV/DIVU operands from EX, computes 64-bit results over several cycles, and stalls the pipeline while computing. Produces one write-enable pulse with the HI/LO results that feed the HI/LO register write port.

## Interface
- `DATA_W`, 32: operand and HI/LO width (matches `RegDataWidth`).
- `clk` in 1: clock.
- `rst` in 1: **one clock; reset is synchronous and active-high.**
- `op_i` in 4: operation. `MD_NOP`=0, `MULT`=1, `MULTU`=2, `DIV`=3, `DIVU`=4, `MADD`=5, `MADDU`=6, `MSUB`=7, `MSUBU`=8. Other values are NOP.
- `start_i` in 1: request to issue `op_i` this cycle.
- `annul_i` in 1: flush; cancels any in-flight or requested operation.
- `src_a_i`, `src_b_i` in 32: rs and rt operands.
- `hi_i`, `lo_i` in 32: current HI/LO values, used only by MADD/MSUB.
- `busy_o` out 1: stall request to the pipeline.
- `done_o` out 1: one-cycle result-valid pulse.
- `we_hi_o`, `we_lo_o` out 1: HI/LO write enables, equal to `done_o`.
- `hi_o`, `lo_o` out 32: registered results.

## Operation
- FSM states: `IDLE`, `MUL`, `DIV`, `DONE`.
- **IDLE**
  - Accept when `start_i && !annul_i && op_i` is valid.
  - On accept, capture operands and op, plus `hi_i`/`lo_i` for MADD/MSUB.
  - MULT/MUL-class op → `MUL`.
  - DIV/DIVU with `src_b_i != 0` → `DIV`, counter=0.
  - DIV/DIVU with `src_b_i == 0` → `DONE`, with `hi = src_a`, `lo = 32'hFFFF_FFFF`.
- **MUL**: one cycle. Registers the 64-bit product: signed for MULT/MADD/MSUB, unsigned for the `U` forms. MADD adds `{hi,lo}` captured at issue; MSUB subtracts the product from it, modulo 2^64. → `DONE`.
- **DIV**: 32 iterations of restoring division on operand magnitudes, one quotient bit per cycle, counter 0..31.
  - After step 31, apply the sign fix for DIV: quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - → `DONE`.
  - `0x80000000 / 0xFFFFFFFF` (DIV) gives `lo = 0x80000000`, `hi = 0`.
- **DONE**: one cycle. `done_o = we_hi_o = we_lo_o = 1`, `hi_o`/`lo_o` valid. → `IDLE`. A new start is not accepted in this cycle.
- `busy_o = (IDLE && accept) || MUL || DIV`. It is combinational on `start_i`, so the issuing instruction stalls from its first cycle. `busy_o` is 0 in `DONE`, so the instruction advances together with the write.
- `start_i` while not in `IDLE`: ignored.
- `annul_i` in `MUL` or `DIV`: → `IDLE` at the next edge, no write, `busy_o` drops that cycle. `annul_i` in `DONE`: write still occurs (already committed).
- `rst`, including mid-operation: state `IDLE`, counter 0, all outputs 0 (`hi_o`, `lo_o` = 0).
- `hi_o`/`lo_o` hold their last value outside `DONE`; only the enables gate the write.

## Timing
- Issue cycle N (start accepted).
- MUL-class: `done_o` in cycle N+2; `busy_o` high in cycles N and N+1.
- DIV-class: `done_o` in cycle N+33; `busy_o` high in cycles N..N+32.
- Divide by zero: `done_o` in cycle N+1.
- Results appear on a posedge. The HI/LO register file captures them on the following negedge within the `DONE` cycle.
- Back-to-back: the earliest next accept is the cycle after `DONE`.

## Configuration
- `MULDIV_MADD_EN` defined: MADD/MADDU/MSUB/MSUBU are accepted and use `hi_i`/`lo_i`.
- Not defined: op codes 5..8 are treated as NOP (not accepted, `busy_o` = 0). `hi_i`/`lo_i` are unused and the accumulate adder is removed.

## Structure
- Shared defines file holds:
  - op codes `MD_*`
  - FSM state encodings
  - `RegDataWidth`, `ZeroWord`, `RstEnable`, `WriteEnable`
- Sub-module `muldiv_div_core`: unsigned 32-step restoring divider with a `load` input, a step counter, and outputs `quot`, `rem`, `last`. Sign handling stays in `muldiv_unit`.

## Test plan
- MULT -3 × 5 → `done_o` at N+2, `hi` = `FFFFFFFF`, `lo` = `FFFFFFF1`. MULTU on the same bit patterns → `hi` = `00000004`, `lo` = `FFFFFFF1`.
- DIV -7 / 2 → `done_o` at N+33, `lo` = `FFFFFFFD` (-3), `hi` = `FFFFFFFF` (-1). DIVU 100/7 → `lo` = 14, `hi` = 2.
- DIV x / 0 with x = `12345678` → `done_o` at N+1, `hi` = `12345678`, `lo` = `FFFFFFFF`.
- DIV started, `annul_i` at N+10 → no `done_o`, `busy_o` = 0 from N+10. A new MULT at N+11 completes at N+13.
- `rst` asserted at N+5 of a DIV → all outputs 0 next cycle, no write. A start held during `busy_o` is ignored.
- With `MULDIV_MADD_EN`: `hi_i:lo_i` = `0:00000010`, MADD 2×3 → `lo` = `00000016`. MSUBU 1×`20` → `lo` = `FFFFFFF0`, `hi` = `FFFFFFFF`.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit shared definitions: widths, op codes, FSM states, op decode helpers.
// Optional accumulate ops are enabled with `define MULDIV_MADD_EN.
package muldiv_unit_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned RegDataWidth = DATA_W;
  localparam int unsigned OpW          = 4;
  localparam int unsigned CntW         = 5;

  localparam logic [RegDataWidth-1:0] ZeroWord = '0;
  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [OpW-1:0] MD_NOP   = 4'd0;
  localparam logic [OpW-1:0] MD_MULT  = 4'd1;
  localparam logic [OpW-1:0] MD_MULTU = 4'd2;
  localparam logic [OpW-1:0] MD_DIV   = 4'd3;
  localparam logic [OpW-1:0] MD_DIVU  = 4'd4;
  localparam logic [OpW-1:0] MD_MADD  = 4'd5;
  localparam logic [OpW-1:0] MD_MADDU = 4'd6;
  localparam logic [OpW-1:0] MD_MSUB  = 4'd7;
  localparam logic [OpW-1:0] MD_MSUBU = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Ops that take the single-cycle multiplier path.
  function automatic logic op_is_mul(input logic [OpW-1:0] op);
`ifdef MULDIV_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  function automatic logic op_is_div(input logic [OpW-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Two's-complement interpretation of the operands.
  function automatic logic op_is_signed(input logic [OpW-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic op_valid(input logic [OpW-1:0] op);
    return op_is_mul(op) || op_is_div(op);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> muldiv_unit request/result bundle.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic [OpW-1:0]    op_i;
  logic              start_i;
  logic              annul_i;
  logic [DATA_W-1:0] src_a_i;
  logic [DATA_W-1:0] src_b_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              busy_o;
  logic              done_o;
  logic              we_hi_o;
  logic              we_lo_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output op_i, start_i, annul_i, src_a_i, src_b_i, hi_i, lo_i,
    input  busy_o, done_o, we_hi_o, we_lo_o, hi_o, lo_o
  );

  modport slave (
    input  op_i, start_i, annul_i, src_a_i, src_b_i, hi_i, lo_i,
    output busy_o, done_o, we_hi_o, we_lo_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_div_core.sv
// Unsigned 32-step restoring divider, one quotient bit per cycle.
// o_quot/o_rem are the results of the step taken this cycle; final when o_last is high.
module muldiv_div_core
  import muldiv_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_last
);

  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_divisor;
  logic [CntW-1:0]   r_cnt;
  logic              r_run;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;
  logic [DATA_W-1:0] w_quot_nxt;
  logic [DATA_W-1:0] w_rem_nxt;

  // Shift in the next dividend bit and trial-subtract the divisor.
  assign w_shift    = {r_rem, r_quot[DATA_W-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_rem_nxt  = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_quot_nxt = {r_quot[DATA_W-2:0], w_ge};

  assign o_quot = w_quot_nxt;
  assign o_rem  = w_rem_nxt;
  assign o_last = r_run && (r_cnt == CntW'(DATA_W - 1));

  // Step register: load restarts, otherwise advance while running.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_quot    <= ZeroWord;
      r_rem     <= ZeroWord;
      r_divisor <= ZeroWord;
      r_cnt     <= '0;
      r_run     <= 1'b0;
    end else if (i_load) begin
      r_quot    <= i_dividend;
      r_rem     <= ZeroWord;
      r_divisor <= i_divisor;
      r_cnt     <= '0;
      r_run     <= 1'b1;
    end else if (r_run) begin
      r_quot <= w_quot_nxt;
      r_rem  <= w_rem_nxt;
      r_cnt  <= r_cnt + CntW'(1);
      if (o_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit feeding the HI/LO write port.
// `define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  md_state_e         r_state;
  logic [OpW-1:0]    r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_done;

  logic                w_accept;
  logic                w_in_signed;
  logic [DATA_W-1:0]   w_div_dividend;
  logic [DATA_W-1:0]   w_div_divisor;
  logic                w_div_load;
  logic [DATA_W-1:0]   w_div_quot;
  logic [DATA_W-1:0]   w_div_rem;
  logic                w_div_last;
  logic                w_sgn;
  logic [2*DATA_W-1:0] w_a64;
  logic [2*DATA_W-1:0] w_b64;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_mul_res;
  logic [DATA_W-1:0]   w_q_fix;
  logic [DATA_W-1:0]   w_r_fix;

  // Issue decode; divider operands are magnitudes taken straight from the bus.
  assign w_accept       = (r_state == ST_IDLE) && bus.start_i && !bus.annul_i && op_valid(bus.op_i);
  assign w_in_signed    = op_is_signed(bus.op_i);
  assign w_div_dividend = (w_in_signed && bus.src_a_i[DATA_W-1]) ? -bus.src_a_i : bus.src_a_i;
  assign w_div_divisor  = (w_in_signed && bus.src_b_i[DATA_W-1]) ? -bus.src_b_i : bus.src_b_i;
  assign w_div_load     = w_accept && op_is_div(bus.op_i) && (bus.src_b_i != ZeroWord);

  muldiv_div_core u_div_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_div_load),
    .i_dividend (w_div_dividend),
    .i_divisor  (w_div_divisor),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem),
    .o_last     (w_div_last)
  );

  // Sign-extend for signed ops; the low 64 bits of the product are then correct either way.
  assign w_sgn  = op_is_signed(r_op);
  assign w_a64  = {{DATA_W{w_sgn & r_a[DATA_W-1]}}, r_a};
  assign w_b64  = {{DATA_W{w_sgn & r_b[DATA_W-1]}}, r_b};
  assign w_prod = w_a64 * w_b64;

`ifdef MULDIV_MADD_EN
  logic [2*DATA_W-1:0] r_acc;

  // Accumulate against HI/LO captured at issue.
  always_comb begin
    w_mul_res = w_prod;
    if ((r_op == MD_MADD) || (r_op == MD_MADDU)) begin
      w_mul_res = r_acc + w_prod;
    end else if ((r_op == MD_MSUB) || (r_op == MD_MSUBU)) begin
      w_mul_res = r_acc - w_prod;
    end
  end

  // Snapshot of HI/LO for accumulate ops.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= {bus.hi_i, bus.lo_i};
    end
  end
`else
  logic w_unused_hilo;

  assign w_mul_res     = w_prod;
  assign w_unused_hilo = ^{bus.hi_i, bus.lo_i};
`endif

  // Quotient negated on differing signs; remainder follows the dividend.
  assign w_q_fix = (w_sgn && (r_a[DATA_W-1] ^ r_b[DATA_W-1])) ? -w_div_quot : w_div_quot;
  assign w_r_fix = (w_sgn && r_a[DATA_W-1]) ? -w_div_rem : w_div_rem;

  // Control FSM with registered results and write pulse.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= ST_IDLE;
      r_op    <= MD_NOP;
      r_a     <= ZeroWord;
      r_b     <= ZeroWord;
      r_hi    <= ZeroWord;
      r_lo    <= ZeroWord;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= bus.op_i;
            r_a  <= bus.src_a_i;
            r_b  <= bus.src_b_i;
            if (op_is_div(bus.op_i)) begin
              if (bus.src_b_i == ZeroWord) begin
                r_hi    <= bus.src_a_i;
                r_lo    <= '1;
                r_done  <= WriteEnable;
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_DIV;
              end
            end else begin
              r_state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (bus.annul_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_hi    <= w_mul_res[2*DATA_W-1:DATA_W];
            r_lo    <= w_mul_res[DATA_W-1:0];
            r_done  <= WriteEnable;
            r_state <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (bus.annul_i) begin
            r_state <= ST_IDLE;
          end else if (w_div_last) begin
            r_hi    <= w_r_fix;
            r_lo    <= w_q_fix;
            r_done  <= WriteEnable;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall from the issue cycle; released on annul and during the write cycle.
  assign bus.busy_o  = w_accept || (((r_state == ST_MUL) || (r_state == ST_DIV)) && !bus.annul_i);
  assign bus.done_o  = r_done;
  assign bus.we_hi_o = r_done;
  assign bus.we_lo_o = r_done;
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi_in, input logic [31:0] lo_in,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi_in = hi_in; v.lo_in = lo_in;
    v.exp_hi = exp_hi; v.exp_lo = exp_lo; v.lat = lat;
    return v;
  endfunction

  // Issue at the current negedge, track to the write pulse, check result and timing.
  task automatic run_op(input string tag, input vec_t v, input bit hold);
    int lat;
    int busy_low;
    bus.op_i    = v.op;
    bus.src_a_i = v.a;
    bus.src_b_i = v.b;
    bus.hi_i    = v.hi_in;
    bus.lo_i    = v.lo_in;
    bus.start_i = 1'b1;
    #1;
    check({tag, "_busy_issue"}, 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    lat = 1;
    busy_low = 0;
    if (hold) begin
      bus.op_i    = MD_MULT;
      bus.src_a_i = 32'h0000_1111;
      bus.src_b_i = 32'h0000_2222;
    end else begin
      bus.start_i = 1'b0;
    end
    while (bus.done_o !== 1'b1 && lat < 40) begin
      if (bus.busy_o !== 1'b1) busy_low++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_busy_low"}, 64'(busy_low), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(v.exp_hi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(v.exp_lo));
    check({tag, "_we"}, 64'({bus.we_hi_o, bus.we_lo_o}), 64'd3);
    check({tag, "_busy_done"}, 64'(bus.busy_o), 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 64'(bus.done_o), 64'd0);
    check({tag, "_hold"}, {bus.hi_o, bus.lo_o}, {v.exp_hi, v.exp_lo});
  endtask

  // Request must not be accepted: no stall, no write.
  task automatic run_nop(input string tag, input logic [3:0] op);
    int dones;
    bus.op_i    = op;
    bus.src_a_i = 32'd2;
    bus.src_b_i = 32'd3;
    bus.start_i = 1'b1;
    #1;
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done_o !== 1'b0) dones++;
    end
    bus.start_i = 1'b0;
    check({tag, "_dones"}, 64'(dones), 64'd0);
  endtask

  initial begin
    int dones;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.op_i = MD_NOP; bus.start_i = 1'b0; bus.annul_i = 1'b0;
    bus.src_a_i = '0; bus.src_b_i = '0; bus.hi_i = '0; bus.lo_i = '0;

    vecs.push_back(mk(MD_MULT,  32'hFFFF_FFFD, 32'h5,         32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2));
    vecs.push_back(mk(MD_MULTU, 32'hFFFF_FFFD, 32'h5,         32'h0,         32'h0,         32'h0000_0004, 32'hFFFF_FFF1, 2));
    vecs.push_back(mk(MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_0001, 2));
    vecs.push_back(mk(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFE, 32'h0000_0001, 2));
    vecs.push_back(mk(MD_DIV,   32'hFFFF_FFF9, 32'h2,         32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33));
    vecs.push_back(mk(MD_DIVU,  32'd100,       32'd7,         32'h0,         32'h0,         32'd2,         32'd14,        33));
    vecs.push_back(mk(MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0,         32'h0,         32'h0000_0001, 32'hFFFF_FFFD, 33));
    vecs.push_back(mk(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0000_0000, 32'h8000_0000, 33));
    vecs.push_back(mk(MD_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0,         32'h0,         32'h0000_000F, 32'h0FFF_FFFF, 33));
    vecs.push_back(mk(MD_DIV,   32'h1234_5678, 32'h0,         32'h0,         32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 1));
    vecs.push_back(mk(MD_DIVU,  32'h0000_0005, 32'h0,         32'h0,         32'h0,         32'h0000_0005, 32'hFFFF_FFFF, 1));
`ifdef MULDIV_MADD_EN
    vecs.push_back(mk(MD_MADD,  32'd2,         32'd3,         32'h0,         32'h10,        32'h0000_0000, 32'h0000_0016, 2));
    vecs.push_back(mk(MD_MSUBU, 32'd1,         32'h20,        32'h0,         32'h10,        32'hFFFF_FFFF, 32'hFFFF_FFF0, 2));
    vecs.push_back(mk(MD_MSUB,  32'hFFFF_FFFF, 32'd4,         32'h0,         32'h10,        32'h0000_0000, 32'h0000_0014, 2));
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(bus.busy_o), 64'd0);
    check("reset_done", 64'({bus.done_o, bus.we_hi_o, bus.we_lo_o}), 64'd0);
    check("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("v%0d", i), vecs[i], 1'b0);
    end

    // Undefined op codes are never accepted.
    run_nop("nop0", MD_NOP);
    run_nop("nop9", 4'd9);
    run_nop("nop15", 4'd15);
`ifndef MULDIV_MADD_EN
    run_nop("nop_madd", MD_MADD);
    run_nop("nop_msubu", MD_MSUBU);
`endif

    // Start held high across a divide: ignored until after the write cycle.
    run_op("hold", mk(MD_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 33), 1'b1);

    // Annul a divide at N+10, then a MULT at N+11 completes at N+13.
    bus.op_i = MD_DIV; bus.src_a_i = 32'hFFFF_FFF9; bus.src_b_i = 32'h2; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    check("annul_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul_nodone", 64'(bus.done_o), 64'd0);
    run_op("post_annul", mk(MD_MULT, 32'hFFFF_FFFD, 32'h5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2), 1'b0);

    // Reset in the middle of a divide clears everything and suppresses the write.
    bus.op_i = MD_DIVU; bus.src_a_i = 32'd100; bus.src_b_i = 32'd7; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_done", 64'({bus.done_o, bus.we_hi_o, bus.we_lo_o}), 64'd0);
    check("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o !== 1'b0) dones++;
    end
    check("midrst_nowrite", 64'(dones), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
